// File: rtl/gfx_calc_address_pipe.sv
// gfx_calc_address_pipe
// Pipelined graphics address calculator. Turns a pixel (x,y) plus the bitmap
// base, width, height and colour depth into the byte address of the memory
// strip holding that pixel, the pixel's mask begin/end bits and colour-bits
// end bit inside the strip, and a clip flag. Three register stages share one
// global enable, so the whole pipe advances or holds as a unit.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   in_valid/in_ready  request handshake (in_ready = !out_valid || out_ready)
//   base_address_i     bitmap base byte address
//   color_depth_i      0=8bpp 1=16bpp 2=24bpp 3=32bpp
//   bmp_width_i        pixels per line
//   bmp_height_i       number of lines
//   x_coord_i          pixel x
//   y_coord_i          pixel y
//   tag_i              sideband tag, returned unchanged on tag_o
//   out_valid/out_ready result handshake
//   address_o          strip-aligned byte address (wraps at AW bits)
//   mb_o, me_o, ce_o   mask begin, mask end, colour-bits end bit in the strip
//   clip_o             pixel lies outside the bitmap
//   tag_o              tag belonging to this result
module gfx_calc_address_pipe #(
  parameter int SW = 128,
  parameter int AW = 32,
  parameter int CW = 16,
  parameter int TW = 8,
  parameter int BN = $clog2(SW) - 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] base_address_i,
  input  logic [1:0]    color_depth_i,
  input  logic [CW-1:0] bmp_width_i,
  input  logic [CW-1:0] bmp_height_i,
  input  logic [CW-1:0] x_coord_i,
  input  logic [CW-1:0] y_coord_i,
  input  logic [TW-1:0] tag_i,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] address_o,
  output logic [BN:0]   mb_o,
  output logic [BN:0]   me_o,
  output logic [BN:0]   ce_o,
  output logic          clip_o,
  output logic [TW-1:0] tag_o
);

  localparam logic [1:0] BPP8  = 2'd0;
  localparam logic [1:0] BPP16 = 2'd1;
  localparam logic [1:0] BPP24 = 2'd2;
  localparam logic [1:0] BPP32 = 2'd3;

  localparam int BW    = BN + 1;
  localparam int SB    = $clog2(SW / 8);
  localparam int PPS8  = SW / 8;
  localparam int PPS16 = SW / 16;
  localparam int PPS24 = SW / 24;
  localparam int PPS32 = SW / 32;
  localparam int SH8   = $clog2(PPS8);
  localparam int SH16  = $clog2(PPS16);
  localparam int SH32  = $clog2(PPS32);

  // Dividend is one bit wider than a coordinate so that width+pps-1 (used for
  // the ceiling division) fits. For a d-bit... for an N-bit dividend and
  // divisor p, m = ceil(2^(N+ceil(log2 p)) / p) gives floor(n*m >> shift) ==
  // floor(n/p) for every n < 2^N, and m fits in N+1 bits.
  localparam int DW  = CW + 1;
  localparam int PW  = 2 * DW + 1;
  localparam int L24 = $clog2(PPS24);
  localparam int S24 = DW + L24;
  localparam logic [DW:0] M24 =
    (DW+1)'(((64'd1 << S24) + 64'(PPS24) - 64'd1) / 64'(PPS24));

  function automatic logic [CW-1:0] ppsOf(input logic [1:0] depth);
    case (depth)
      BPP8:    ppsOf = CW'(PPS8);
      BPP24:   ppsOf = CW'(PPS24);
      BPP32:   ppsOf = CW'(PPS32);
      default: ppsOf = CW'(PPS16);
    endcase
  endfunction

  function automatic logic [15:0] bppOf(input logic [1:0] depth);
    case (depth)
      BPP8:    bppOf = 16'd8;
      BPP24:   bppOf = 16'd24;
      BPP32:   bppOf = 16'd32;
      default: bppOf = 16'd16;
    endcase
  endfunction

  // Colour bits minus one; 32bpp carries 30 colour bits.
  function automatic logic [15:0] cbm1Of(input logic [1:0] depth);
    case (depth)
      BPP8:    cbm1Of = 16'd7;
      BPP24:   cbm1Of = 16'd23;
      BPP32:   cbm1Of = 16'd29;
      default: cbm1Of = 16'd15;
    endcase
  endfunction

  // Power-of-two strip populations divide by shifting; 24bpp uses the
  // exact reciprocal multiply.
  function automatic logic [CW-1:0] divPps(input logic [DW-1:0] n,
                                           input logic [1:0]    depth);
    logic [PW-1:0] prod;
    prod = PW'(n) * PW'(M24);
    case (depth)
      BPP8:    divPps = CW'(n >> SH8);
      BPP24:   divPps = CW'(prod >> S24);
      BPP32:   divPps = CW'(n >> SH32);
      default: divPps = CW'(n >> SH16);
    endcase
  endfunction

  logic          en;

  logic          v1_q, v2_q, v3_q;

  logic [AW-1:0] base1_q;
  logic [1:0]    depth1_q;
  logic [CW-1:0] y1_q;
  logic [CW-1:0] stripNum1_q, stripNum1_d;
  logic [CW-1:0] numStrips1_q, numStrips1_d;
  logic [BW-1:0] idx1_q, idx1_d;
  logic          clip1_q, clip1_d;
  logic [TW-1:0] tag1_q;
  logic [CW-1:0] pps0;
  logic [CW-1:0] xFloor;

  logic [AW-1:0] base2_q;
  logic [AW-1:0] lin2_q, lin2_d;
  logic [BW-1:0] mb2_q, mb2_d;
  logic [BW-1:0] me2_q, me2_d;
  logic [BW-1:0] ce2_q, ce2_d;
  logic          clip2_q;
  logic [TW-1:0] tag2_q;
  logic [15:0]   bpp2, cbm12, mbWide;

  logic [AW-1:0] addr3_q, addr3_d;
  logic [BW-1:0] mb3_q, me3_q, ce3_q;
  logic          clip3_q;
  logic [TW-1:0] tag3_q;

  assign en        = !v3_q || out_ready;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign address_o = addr3_q;
  assign mb_o      = mb3_q;
  assign me_o      = me3_q;
  assign ce_o      = ce3_q;
  assign clip_o    = clip3_q;
  assign tag_o     = tag3_q;

  // First stage: the two divisions by pixels-per-strip and the clip test.
  always_comb begin
    pps0         = ppsOf(color_depth_i);
    stripNum1_d  = divPps({1'b0, x_coord_i}, color_depth_i);
    xFloor       = stripNum1_d * pps0;
    idx1_d       = BW'(x_coord_i - xFloor);
    numStrips1_d = divPps({1'b0, bmp_width_i} + {1'b0, pps0} - DW'(1),
                          color_depth_i);
    clip1_d      = (x_coord_i >= bmp_width_i) || (y_coord_i >= bmp_height_i);
  end

  // Second stage: bit positions inside the strip and the linear strip index.
  // The strip index is kept modulo 2^AW since the address wraps anyway.
  always_comb begin
    bpp2   = bppOf(depth1_q);
    cbm12  = cbm1Of(depth1_q);
    mbWide = 16'(idx1_q) * bpp2;
    mb2_d  = BW'(mbWide);
    me2_d  = BW'(mbWide + bpp2 - 16'd1);
    ce2_d  = BW'(mbWide + cbm12);
    lin2_d = AW'(numStrips1_q) * AW'(y1_q) + AW'(stripNum1_q);
  end

  // Third stage: scale the strip index to bytes and add the base.
  always_comb begin
    addr3_d = base2_q + (lin2_q << SB);
  end

  // Pipeline registers. Data only loads behind a valid request, so bubbles
  // leave the last result in place rather than clocking in idle inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q         <= 1'b0;
      v2_q         <= 1'b0;
      v3_q         <= 1'b0;
      base1_q      <= '0;
      depth1_q     <= '0;
      y1_q         <= '0;
      stripNum1_q  <= '0;
      numStrips1_q <= '0;
      idx1_q       <= '0;
      clip1_q      <= 1'b0;
      tag1_q       <= '0;
      base2_q      <= '0;
      lin2_q       <= '0;
      mb2_q        <= '0;
      me2_q        <= '0;
      ce2_q        <= '0;
      clip2_q      <= 1'b0;
      tag2_q       <= '0;
      addr3_q      <= '0;
      mb3_q        <= '0;
      me3_q        <= '0;
      ce3_q        <= '0;
      clip3_q      <= 1'b0;
      tag3_q       <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      v2_q <= v1_q;
      v3_q <= v2_q;
      if (in_valid) begin
        base1_q      <= base_address_i;
        depth1_q     <= color_depth_i;
        y1_q         <= y_coord_i;
        stripNum1_q  <= stripNum1_d;
        numStrips1_q <= numStrips1_d;
        idx1_q       <= idx1_d;
        clip1_q      <= clip1_d;
        tag1_q       <= tag_i;
      end
      if (v1_q) begin
        base2_q <= base1_q;
        lin2_q  <= lin2_d;
        mb2_q   <= mb2_d;
        me2_q   <= me2_d;
        ce2_q   <= ce2_d;
        clip2_q <= clip1_q;
        tag2_q  <= tag1_q;
      end
      if (v2_q) begin
        addr3_q <= addr3_d;
        mb3_q   <= mb2_q;
        me3_q   <= me2_q;
        ce3_q   <= ce2_q;
        clip3_q <= clip2_q;
        tag3_q  <= tag2_q;
      end
    end
  end

endmodule

// File: tb/tb_gfx_calc_address_pipe.sv
// tb_gfx_calc_address_pipe
// Self-checking bench for gfx_calc_address_pipe. A monitor predicts every
// accepted request with a plain-arithmetic model and compares each consumed
// result in order; the initial block walks directed cases, back-pressure,
// a 24bpp coordinate sweep, random traffic and a mid-stream reset.
module tb_gfx_calc_address_pipe;

  localparam int SW = 128;
  localparam int AW = 32;
  localparam int CW = 16;
  localparam int TW = 8;
  localparam int BN = $clog2(SW) - 1;
  localparam int BW = BN + 1;

  typedef struct {
    logic [AW-1:0] base;
    logic [1:0]    depth;
    logic [CW-1:0] w;
    logic [CW-1:0] h;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [TW-1:0] tag;
  } req_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [BW-1:0] mb;
    logic [BW-1:0] me;
    logic [BW-1:0] ce;
    logic          clip;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] base_address_i;
  logic [1:0]    color_depth_i;
  logic [CW-1:0] bmp_width_i;
  logic [CW-1:0] bmp_height_i;
  logic [CW-1:0] x_coord_i;
  logic [CW-1:0] y_coord_i;
  logic [TW-1:0] tag_i;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] address_o;
  logic [BN:0]   mb_o;
  logic [BN:0]   me_o;
  logic [BN:0]   ce_o;
  logic          clip_o;
  logic [TW-1:0] tag_o;

  int   checks = 0;
  int   passes = 0;
  int   fails  = 0;
  exp_t expQ[$];

  logic          stallPrev;
  logic [AW-1:0] hAddr;
  logic [BW-1:0] hMb, hMe, hCe;
  logic          hClip;
  logic [TW-1:0] hTag;

  gfx_calc_address_pipe #(.SW(SW), .AW(AW), .CW(CW), .TW(TW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .base_address_i (base_address_i),
    .color_depth_i  (color_depth_i),
    .bmp_width_i    (bmp_width_i),
    .bmp_height_i   (bmp_height_i),
    .x_coord_i      (x_coord_i),
    .y_coord_i      (y_coord_i),
    .tag_i          (tag_i),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .address_o      (address_o),
    .mb_o           (mb_o),
    .me_o           (me_o),
    .ce_o           (ce_o),
    .clip_o         (clip_o),
    .tag_o          (tag_o)
  );

  always #5 clk = ~clk;

  // Reference: pixels per strip by integer division, strip and index by
  // plain divide/modulo, address reduced modulo 2^AW.
  function automatic exp_t model(input req_t r);
    exp_t   e;
    longint bpp, cbits, pps, strip, idx, ns, a;
    case (r.depth)
      2'd0:    begin bpp = 8;  cbits = 8;  end
      2'd2:    begin bpp = 24; cbits = 24; end
      2'd3:    begin bpp = 32; cbits = 30; end
      default: begin bpp = 16; cbits = 16; end
    endcase
    pps    = SW / bpp;
    strip  = longint'(r.x) / pps;
    idx    = longint'(r.x) % pps;
    ns     = (longint'(r.w) + pps - 1) / pps;
    a      = longint'(r.base) + (ns * longint'(r.y) + strip) * (SW / 8);
    e.addr = a[AW-1:0];
    e.mb   = BW'(idx * bpp);
    e.me   = BW'(idx * bpp + bpp - 1);
    e.ce   = BW'(idx * bpp + cbits - 1);
    e.clip = (r.x >= r.w) || (r.y >= r.h);
    e.tag  = r.tag;
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] obs,
                     input logic [63:0] expv);
    checks++;
    assert (obs === expv) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, expv);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    chk("address", 64'(address_o), 64'(e.addr));
    chk("mb", 64'(mb_o), 64'(e.mb));
    chk("me", 64'(me_o), 64'(e.me));
    chk("ce", 64'(ce_o), 64'(e.ce));
    chk("clip", 64'(clip_o), 64'(e.clip));
    chk("tag", 64'(tag_o), 64'(e.tag));
  endtask

  // Drives one cycle from just after a rising edge to just after the next.
  task automatic applyStimulus(input req_t r, input logic valid,
                               input logic ready, output logic acc);
    base_address_i = r.base;
    color_depth_i  = r.depth;
    bmp_width_i    = r.w;
    bmp_height_i   = r.h;
    x_coord_i      = r.x;
    y_coord_i      = r.y;
    tag_i          = r.tag;
    in_valid       = valid;
    out_ready      = ready;
    @(negedge clk);
    acc = valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  function automatic req_t mkReq(input logic [AW-1:0] base, input logic [1:0] d,
                                 input int w, input int h, input int x,
                                 input int y, input int tag);
    req_t r;
    r.base = base; r.depth = d; r.w = CW'(w); r.h = CW'(h);
    r.x = CW'(x); r.y = CW'(y); r.tag = TW'(tag);
    return r;
  endfunction

  function automatic req_t randReq();
    req_t r;
    r.base  = $urandom;
    r.depth = 2'($urandom_range(0, 3));
    r.w     = CW'($urandom_range(1, 65535));
    r.h     = CW'($urandom_range(1, 65535));
    r.x     = ($urandom_range(0, 3) == 0) ? CW'($urandom)
                                          : CW'($urandom_range(0, int'(r.w) - 1));
    r.y     = ($urandom_range(0, 3) == 0) ? CW'($urandom)
                                          : CW'($urandom_range(0, int'(r.h) - 1));
    r.tag   = TW'($urandom);
    return r;
  endfunction

  // Single request into an idle pipe with out_ready high: checks the
  // three-cycle latency and the hand-computed result.
  task automatic runDirected(input string name, input req_t r,
                             input int eAddr, input int eMb, input int eMe,
                             input int eCe, input int eClip);
    logic acc;
    applyStimulus(r, 1'b1, 1'b1, acc);
    in_valid = 1'b0;
    chk({name, "_accept"}, 64'(acc), 64'd1);
    @(posedge clk); #1;
    chk({name, "_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_addr"}, 64'(address_o), 64'(unsigned'(eAddr)));
    chk({name, "_mb"}, 64'(mb_o), 64'(eMb));
    chk({name, "_me"}, 64'(me_o), 64'(eMe));
    chk({name, "_ce"}, 64'(ce_o), 64'(eCe));
    chk({name, "_clip"}, 64'(clip_o), 64'(eClip));
    @(posedge clk); #1;
  endtask

  // Monitor: handshake rule, output stability while stalled, and in-order
  // scoreboard of every accepted request.
  always @(negedge clk) begin
    exp_t e;
    req_t r;
    if (!rst_n) begin
      stallPrev <= 1'b0;
    end else begin
      chk("in_ready_rule", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (stallPrev) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_addr", 64'(address_o), 64'(hAddr));
        chk("hold_mb", 64'(mb_o), 64'(hMb));
        chk("hold_me", 64'(me_o), 64'(hMe));
        chk("hold_ce", 64'(ce_o), 64'(hCe));
        chk("hold_clip", 64'(clip_o), 64'(hClip));
        chk("hold_tag", 64'(tag_o), 64'(hTag));
      end
      if (in_valid && in_ready) begin
        r = mkReq(base_address_i, color_depth_i, int'(bmp_width_i),
                  int'(bmp_height_i), int'(x_coord_i), int'(y_coord_i),
                  int'(tag_i));
        expQ.push_back(model(r));
      end
      if (out_valid && out_ready) begin
        if (expQ.size() == 0) begin
          chk("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          e = expQ.pop_front();
          checkOutput(e);
        end
      end
      stallPrev <= out_valid && !out_ready;
      hAddr     <= address_o;
      hMb       <= mb_o;
      hMe       <= me_o;
      hCe       <= ce_o;
      hClip     <= clip_o;
      hTag      <= tag_o;
    end
  end

  initial begin
    req_t r;
    logic acc;
    logic pat [4];
    int   sent, pi;

    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    base_address_i = '0; color_depth_i = '0; bmp_width_i = '0;
    bmp_height_i = '0; x_coord_i = '0; y_coord_i = '0; tag_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_addr", 64'(address_o), 64'd0);
    chk("rst_masks", 64'({mb_o, me_o, ce_o}), 64'd0);
    chk("rst_clip_tag", 64'({clip_o, tag_o}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] directed cases");
    runDirected("bpp16", mkReq(32'h1000, 2'd1, 640, 480, 19, 2, 1),
                32'h1A20, 48, 63, 63, 0);
    runDirected("bpp24", mkReq(32'h0, 2'd2, 640, 480, 7, 1, 2),
                2064, 48, 71, 71, 0);
    runDirected("bpp24_last", mkReq(32'h0, 2'd2, 640, 480, 4, 0, 3),
                0, 96, 119, 119, 0);
    runDirected("bpp32", mkReq(32'h0, 2'd3, 640, 480, 5, 0, 4),
                16, 32, 63, 61, 0);
    runDirected("bpp8", mkReq(32'h2000, 2'd0, 640, 480, 15, 0, 5),
                32'h2000, 120, 127, 127, 0);
    runDirected("clip_x", mkReq(32'h0, 2'd1, 640, 480, 640, 0, 6),
                1280, 0, 15, 15, 1);
    runDirected("clip_y", mkReq(32'h0, 2'd1, 640, 480, 0, 480, 7),
                614400, 0, 15, 15, 1);
    runDirected("corner", mkReq(32'h0, 2'd1, 640, 480, 639, 479, 8),
                614384, 112, 127, 127, 0);
    runDirected("wrap", mkReq(32'hFFFF_FFF0, 2'd1, 640, 480, 8, 0, 9),
                0, 0, 15, 15, 0);

    $display("[TB] back-pressure stream");
    sent = 0; pi = 0;
    while (sent < 6 && pi < 200) begin
      r = mkReq(32'h4000, 2'd1, 640, 480, 10 * sent + 3, sent, 8'h10 + sent);
      applyStimulus(r, 1'b1, pat[pi % 4], acc);
      pi++;
      if (acc) sent++;
    end
    chk("bp_all_sent", 64'(sent), 64'd6);
    in_valid = 1'b0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(r, 1'b0, pat[pi % 4], acc);
      pi++;
    end
    chk("bp_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] 24bpp coordinate sweep");
    out_ready = 1'b1;
    for (int x = 0; x < 65536; x++) begin
      if (x < 4096 || x >= 61440) begin
        r = randReq();
        r.depth = 2'd2;
        r.x = CW'(x);
        applyStimulus(r, 1'b1, 1'b1, acc);
      end
    end

    $display("[TB] random traffic");
    sent = 0;
    pi = 0;
    while (sent < 3000 && pi < 20000) begin
      if ($urandom_range(0, 4) == 0) begin
        applyStimulus(r, 1'b0, ($urandom_range(0, 3) != 0), acc);
      end else begin
        r = randReq();
        acc = 1'b0;
        while (!acc && pi < 20000) begin
          applyStimulus(r, 1'b1, ($urandom_range(0, 3) != 0), acc);
          pi++;
        end
        sent++;
      end
      pi++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) applyStimulus(r, 1'b0, 1'b1, acc);
    chk("rand_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) begin
      r = mkReq(32'h1234_0000, 2'd1, 640, 480, 100 + i, 7, 8'hA0 + i);
      applyStimulus(r, 1'b1, 1'b0, acc);
    end
    in_valid = 1'b0;
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_addr", 64'(address_o), 64'd0);
    chk("mid_rst_masks", 64'({mb_o, me_o, ce_o}), 64'd0);
    chk("mid_rst_clip_tag", 64'({clip_o, tag_o}), 64'd0);
    #4 rst_n = 1'b1;
    expQ.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end
    runDirected("after_rst", mkReq(32'h1000, 2'd1, 640, 480, 19, 2, 1),
                32'h1A20, 48, 63, 63, 0);
    chk("final_drained", 64'(expQ.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gfx_calc_address_pipe.md
Name: gfx_calc_address_pipe

Overview:
- Pipelined, flow-controlled successor to the fixed-latency graphics address calculator.
- Converts a pixel (x,y) plus bitmap base/width/height/colour depth into:
  - a strip-aligned byte address;
  - the pixel's bit mask begin/end and colour-bits end within the strip;
  - a clip flag.
- Sits between the draw/blit engines and the strip memory port. Results are exact for all coordinates, including 24bpp, where a strip holds a non-power-of-two pixel count.

Parameters:
- SW, 128, strip width in bits; power of two, 32..256.
- AW, 32, address width.
- CW, 16, coordinate/width/height width.
- TW, 8, sideband tag width; the tag is passed through unchanged.
- BN, $clog2(SW)-1, derived msb of bit-position outputs.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid&&in_ready.
- base_address_i  in  AW  bitmap base, byte address.
- color_depth_i  in  2  BPP8/BPP16/BPP24/BPP32 (gfx_pkg encodings).
- bmp_width_i  in  CW  pixels per line.
- bmp_height_i  in  CW  lines.
- x_coord_i  in  CW  pixel x.
- y_coord_i  in  CW  pixel y.
- tag_i  in  TW  sideband.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer ready.
- address_o  out  AW  strip byte address.
- mb_o  out  BN+1  mask begin bit.
- me_o  out  BN+1  mask end bit.
- ce_o  out  BN+1  colour-bits end bit.
- clip_o  out  1  pixel outside bitmap.
- tag_o  out  TW  tag of this result.

Behaviour:
- Derived per depth:
  - bpp = 8/16/24/32.
  - cbpp-1 = 7/15/23/29.
  - pps (pixels per strip) = floor(SW/bpp); for SW=128 this is 16/8/5/4.
  - Strip bytes = SW/8.
  - Unknown encodings behave as BPP16.
- Arithmetic, exact for all CW-bit inputs:
  - strip_num = floor(x/pps)
  - idx = x mod pps
  - mb = idx*bpp
  - me = mb+bpp-1
  - ce = mb+cbpp-1
  - num_strips = ceil(width/pps)
  - address = base + (num_strips*y + strip_num)*(SW/8), truncated to AW bits (wraps).
- Divide-by-pps may use reciprocal multiply, but must be exact; it must be verified for all x in 0..2^CW-1 at every depth.
- clip_o = (x >= width) || (y >= height). Address and masks are still computed when clip_o=1.
- Pipeline: 3 register stages; latency is 3 cycles from acceptance to out_valid when out_ready stays 1.
- Flow control:
  - Global enable en = !out_valid || out_ready; in_ready = en.
  - All stages advance together when en=1 and hold when en=0.
  - Bubbles are not compressed.
  - Throughput is 1/clk.
- All per-request fields, including base, depth, width and tag, travel with the request. Changing inputs between requests needs no flush.
- Output hold: while out_valid && !out_ready, all outputs are stable.
- in_valid=0 on an advancing cycle inserts a bubble; out_valid follows 3 advancing cycles later.
- Reset:
  - rst_n low clears all stage valids, out_valid=0, and all data outputs to 0, asynchronously.
  - In-flight requests are discarded; nothing resumes after reset.
  - in_ready=1 during and after reset.

Test Plan:
- SW=128, BPP16, base=0x1000, width=640, height=480, x=19, y=2, out_ready=1 -> after 3 clk: address=0x1000+(80*2+2)*16=0x1A20, mb=48, me=63, ce=63, clip=0.
- BPP24, base=0, width=640, x=7, y=1 -> num_strips=128, address=(128+1)*16=2064, mb=48, me=71, ce=71. Also sweep all x and compare against the reference model.
- BPP32, x=5, y=0, base=0 -> strip 1, address=16, mb=32, me=63, ce=61. BPP8, x=15 -> mb=120, me=127, address=base.
- Clip: width=640, height=480, x=640, y=0 -> clip_o=1; x=0, y=480 -> clip_o=1; x=639, y=479 -> clip_o=0.
- Back-pressure: stream 6 tagged requests with out_ready toggling 1,0,0,1 -> no loss or duplication; outputs stay stable while stalled; tags emerge in order; in_ready=0 exactly when out_valid&&!out_ready.
- Reset mid-stream: 3 requests in flight, pulse rst_n low for one half-cycle -> out_valid=0 immediately and all outputs 0; no stale result appears afterwards.
